branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver_pkg.sv | 17 +
 rtl/branch_resolver_pred_fifo.sv | 64 ++++++
 rtl/branch_resolver.sv | 142 ++++++++++++++
 tb/tb_branch_resolver.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// rtl/branch_resolver_pkg.sv - shared types and constants for the branch resolver
package branch_resolver_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } br_state_e;

    localparam logic [31:0] DELAY_SLOT_OFFSET = 32'd8;

    typedef struct packed {
        logic        taken;
        logic [31:0] pc;
        logic [31:0] target;
    } pred_entry_t;

endpackage

// File: rtl/branch_resolver_pred_fifo.sv
// rtl/branch_resolver_pred_fifo.sv - in-flight prediction queue with push/pop/clear
module pred_fifo
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  pred_entry_t              wdata_i,
    output pred_entry_t              rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pred_entry_t         mem_q [DEPTH];
    logic [AW-1:0]       rd_ptr_q;
    logic [AW-1:0]       wr_ptr_q;
    logic [CW-1:0]       count_q;
    logic                do_push;
    logic                do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full queue still takes a push when the head leaves on the same edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - matches EX branch outcomes against queued ID predictions
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     Pred_valid,
    input  logic                     Pred_taken,
    input  logic [31:0]              Pred_pc,
    input  logic [31:0]              Pred_target,
    input  logic                     Res_valid,
    input  logic                     Res_taken,
    input  logic [31:0]              Res_target,
    output logic                     Branch_resolved,
    output logic [31:0]              Branch_addr_OUT,
    output logic                     Flush,
    output logic [31:0]              Redirect_pc,
    output logic                     Stall_ID,
    output logic [$clog2(DEPTH):0]   Count,
    output logic [15:0]              Mispredicts,
    output logic                     Err_underflow
);

    localparam int FCW = $clog2(FLUSH_CYCLES + 1);

    br_state_e    state_q, state_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;

    pred_entry_t  push_entry;
    pred_entry_t  head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         run;
    logic         pop_fire;
    logic         push_req;
    logic         underflow;
    logic         mispredict;

    logic         resolved_q, resolved_d;
    logic [31:0]  addr_q, addr_d;
    logic         flush_q, flush_d;
    logic [31:0]  redirect_q, redirect_d;
    logic [15:0]  mp_q, mp_d;
    logic         err_q, err_d;

    assign push_entry = '{taken: Pred_taken, pc: Pred_pc, target: Pred_target};

    always_comb begin
        run        = (state_q == RUN);
        pop_fire   = run && Res_valid && !fifo_empty;
        underflow  = run && Res_valid && fifo_empty;
        mispredict = pop_fire &&
                     ((Res_taken != head.taken) || (Res_taken && (Res_target != head.target)));
        // Anything pushed alongside a mispredict was fetched down the wrong path.
        push_req   = run && Pred_valid && !mispredict;
    end

    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push_i  (push_req),
        .pop_i   (pop_fire),
        .clear_i (mispredict),
        .wdata_i (push_entry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (Count)
    );

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            RUN: begin
                if (mispredict) begin
                    state_d = FLUSH;
                    fcnt_d  = FCW'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - FCW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        resolved_d = pop_fire ? Res_taken : 1'b0;
        addr_d     = pop_fire ? head.pc : 32'd0;
        flush_d    = mispredict;
        redirect_d = redirect_q;
        mp_d       = mp_q;
        err_d      = err_q || underflow;
        if (mispredict) begin
            redirect_d = Res_taken ? Res_target : (head.pc + DELAY_SLOT_OFFSET);
            if (mp_q != 16'hFFFF) begin
                mp_d = mp_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= RUN;
            fcnt_q     <= '0;
            resolved_q <= 1'b0;
            addr_q     <= 32'd0;
            flush_q    <= 1'b0;
            redirect_q <= 32'd0;
            mp_q       <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            resolved_q <= resolved_d;
            addr_q     <= addr_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            mp_q       <= mp_d;
            err_q      <= err_d;
        end
    end

    assign Branch_resolved = resolved_q;
    assign Branch_addr_OUT = addr_q;
    assign Flush           = flush_q;
    assign Redirect_pc     = redirect_q;
    assign Mispredicts     = mp_q;
    assign Err_underflow   = err_q;
    assign Stall_ID        = fifo_full || (state_q == FLUSH);

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed and randomized checks of branch_resolver
module tb_branch_resolver;

    localparam int DEPTH = 4;
    localparam int FLUSH_CYCLES = 2;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int VW = 1 + 32 + 1 + 32 + 1 + CW + 16 + 1;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          Pred_valid = 1'b0;
    logic          Pred_taken = 1'b0;
    logic [31:0]   Pred_pc = '0;
    logic [31:0]   Pred_target = '0;
    logic          Res_valid = 1'b0;
    logic          Res_taken = 1'b0;
    logic [31:0]   Res_target = '0;
    logic          Branch_resolved;
    logic [31:0]   Branch_addr_OUT;
    logic          Flush;
    logic [31:0]   Redirect_pc;
    logic          Stall_ID;
    logic [CW-1:0] Count;
    logic [15:0]   Mispredicts;
    logic          Err_underflow;

    int n_cmp = 0;
    int n_fail = 0;

    branch_resolver #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .CLK(CLK), .RESET(RESET),
        .Pred_valid(Pred_valid), .Pred_taken(Pred_taken), .Pred_pc(Pred_pc), .Pred_target(Pred_target),
        .Res_valid(Res_valid), .Res_taken(Res_taken), .Res_target(Res_target),
        .Branch_resolved(Branch_resolved), .Branch_addr_OUT(Branch_addr_OUT),
        .Flush(Flush), .Redirect_pc(Redirect_pc), .Stall_ID(Stall_ID), .Count(Count),
        .Mispredicts(Mispredicts), .Err_underflow(Err_underflow)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: a queue of outstanding predictions plus flush cycles remaining.
    typedef struct {
        logic        taken;
        logic [31:0] pc;
        logic [31:0] target;
    } ent_t;

    ent_t        mq[$];
    int          m_flush_left;
    logic        m_br, m_flush, m_err;
    logic [31:0] m_addr, m_redir;
    int          m_mp;

    task automatic model_reset();
        mq.delete();
        m_flush_left = 0;
        m_br = 0; m_flush = 0; m_err = 0;
        m_addr = 0; m_redir = 0; m_mp = 0;
    endtask

    task automatic model_step();
        ent_t e;
        bit   mp;
        mp = 0;
        m_br = 0; m_addr = 0; m_flush = 0;
        if (m_flush_left > 0) begin
            m_flush_left--;
        end else begin
            if (Res_valid) begin
                if (mq.size() == 0) begin
                    m_err = 1;
                end else begin
                    e = mq.pop_front();
                    m_addr = e.pc;
                    m_br = Res_taken;
                    mp = (Res_taken != e.taken) || (Res_taken && Res_target != e.target);
                    if (mp) begin
                        m_flush = 1;
                        m_redir = Res_taken ? Res_target : e.pc + 32'd8;
                        if (m_mp < 65535) m_mp++;
                        mq.delete();
                        m_flush_left = FLUSH_CYCLES;
                    end
                end
            end
            if (Pred_valid && !mp && mq.size() < DEPTH) begin
                e.taken = Pred_taken; e.pc = Pred_pc; e.target = Pred_target;
                mq.push_back(e);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        Pred_valid = 0; Pred_taken = 0; Pred_pc = 0; Pred_target = 0;
        Res_valid = 0; Res_taken = 0; Res_target = 0;
    endtask

    task automatic set_pred(input logic v, input logic t, input logic [31:0] pc, input logic [31:0] tg);
        Pred_valid = v; Pred_taken = t; Pred_pc = pc; Pred_target = tg;
    endtask

    task automatic set_res(input logic v, input logic t, input logic [31:0] tg);
        Res_valid = v; Res_taken = t; Res_target = tg;
    endtask

    task automatic apply_reset();
        idle_inputs();
        RESET = 0;
        model_reset();
        #3;
        @(negedge CLK);
        RESET = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (Branch_addr_OUT !== 32'd0 || Branch_resolved !== 1'b0) begin
            n_fail++; $display("FAIL reset_update: addr=%h res=%b required 0/0", Branch_addr_OUT, Branch_resolved); end
        n_cmp++; if (Flush !== 1'b0 || Redirect_pc !== 32'd0) begin
            n_fail++; $display("FAIL reset_flush: flush=%b redirect=%h required 0/0", Flush, Redirect_pc); end
        n_cmp++; if (Count !== '0 || Stall_ID !== 1'b0) begin
            n_fail++; $display("FAIL reset_count: count=%0d stall=%b required 0/0", Count, Stall_ID); end
        n_cmp++; if (Mispredicts !== 16'd0 || Err_underflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_counters: mp=%0d err=%b required 0/0", Mispredicts, Err_underflow); end
    endtask

    task automatic test_correct_predict();
        apply_reset();
        set_pred(1, 1, 32'h0040_0100, 32'h0040_0200);
        tick();
        idle_inputs();
        n_cmp++; if (Count !== CW'(1)) begin
            n_fail++; $display("FAIL first_push_count: got %0d required 1", Count); end
        set_res(1, 1, 32'h0040_0200);
        tick();
        idle_inputs();
        n_cmp++; if (Branch_addr_OUT !== 32'h0040_0100 || Branch_resolved !== 1'b1 || Flush !== 1'b0) begin
            n_fail++; $display("FAIL correct_update: addr=%h res=%b flush=%b required 00400100/1/0",
                               Branch_addr_OUT, Branch_resolved, Flush); end
        tick();
        n_cmp++; if (Branch_addr_OUT !== 32'd0 || Branch_resolved !== 1'b0) begin
            n_fail++; $display("FAIL update_one_cycle: addr=%h res=%b required 0/0", Branch_addr_OUT, Branch_resolved); end
    endtask

    task automatic test_mispredict_taken();
        apply_reset();
        set_pred(1, 0, 32'h0040_0100, 32'h0040_0104);
        tick();
        set_pred(1, 1, 32'h0040_0300, 32'h0040_0400);
        set_res(1, 1, 32'h0040_0180);
        tick();
        set_res(1, 1, 32'h0040_0180);
        n_cmp++; if (Flush !== 1'b1 || Redirect_pc !== 32'h0040_0180 || Mispredicts !== 16'd1) begin
            n_fail++; $display("FAIL mp_taken_flush: flush=%b redirect=%h mp=%0d required 1/00400180/1",
                               Flush, Redirect_pc, Mispredicts); end
        n_cmp++; if (Count !== '0 || Stall_ID !== 1'b1) begin
            n_fail++; $display("FAIL mp_taken_clear: count=%0d stall=%b required 0/1", Count, Stall_ID); end
        tick();
        idle_inputs();
        n_cmp++; if (Flush !== 1'b0 || Stall_ID !== 1'b1 || Redirect_pc !== 32'h0040_0180) begin
            n_fail++; $display("FAIL mp_taken_hold: flush=%b stall=%b redirect=%h required 0/1/00400180",
                               Flush, Stall_ID, Redirect_pc); end
        tick();
        n_cmp++; if (Stall_ID !== 1'b0 || Count !== '0 || Branch_addr_OUT !== 32'd0 || Err_underflow !== 1'b0) begin
            n_fail++; $display("FAIL mp_taken_end: stall=%b count=%0d addr=%h err=%b required 0/0/0/0",
                               Stall_ID, Count, Branch_addr_OUT, Err_underflow); end
    endtask

    task automatic test_mispredict_not_taken();
        apply_reset();
        set_pred(1, 1, 32'h0040_0100, 32'h0040_0200);
        tick();
        idle_inputs();
        set_res(1, 0, 32'h0);
        tick();
        idle_inputs();
        n_cmp++; if (Flush !== 1'b1 || Redirect_pc !== 32'h0040_0108 || Branch_resolved !== 1'b0) begin
            n_fail++; $display("FAIL mp_not_taken: flush=%b redirect=%h res=%b required 1/00400108/0",
                               Flush, Redirect_pc, Branch_resolved); end
        tick(); tick();
    endtask

    task automatic test_full_and_order();
        logic [31:0] exp_pc [4];
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_pred(1, 1, 32'h1000 + 32'(i) * 32'h10, 32'h1040 + 32'(i) * 32'h10);
            tick();
        end
        n_cmp++; if (Count !== CW'(DEPTH) || Stall_ID !== 1'b1) begin
            n_fail++; $display("FAIL full_state: count=%0d stall=%b required 4/1", Count, Stall_ID); end
        set_pred(1, 1, 32'h1040, 32'h1080);
        tick();
        n_cmp++; if (Count !== CW'(DEPTH)) begin
            n_fail++; $display("FAIL full_drop: count=%0d required 4", Count); end
        set_pred(1, 1, 32'h1050, 32'h1090);
        set_res(1, 1, 32'h1040);
        tick();
        idle_inputs();
        n_cmp++; if (Count !== CW'(DEPTH) || Branch_addr_OUT !== 32'h1000) begin
            n_fail++; $display("FAIL full_push_pop: count=%0d addr=%h required 4/00001000", Count, Branch_addr_OUT); end
        exp_pc[0] = 32'h1010; exp_pc[1] = 32'h1020; exp_pc[2] = 32'h1030; exp_pc[3] = 32'h1050;
        for (int i = 0; i < 4; i++) begin
            set_res(1, 1, exp_pc[i] + 32'h40);
            tick();
            n_cmp++; if (Branch_addr_OUT !== exp_pc[i] || Flush !== 1'b0) begin
                n_fail++; $display("FAIL order_%0d: addr=%h flush=%b required %h/0", i, Branch_addr_OUT, Flush, exp_pc[i]); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_underflow();
        apply_reset();
        set_res(1, 1, 32'h2000);
        tick();
        idle_inputs();
        n_cmp++; if (Err_underflow !== 1'b1 || Branch_addr_OUT !== 32'd0 || Branch_resolved !== 1'b0) begin
            n_fail++; $display("FAIL underflow: err=%b addr=%h res=%b required 1/0/0",
                               Err_underflow, Branch_addr_OUT, Branch_resolved); end
        tick(); tick();
        n_cmp++; if (Err_underflow !== 1'b1) begin
            n_fail++; $display("FAIL underflow_sticky: err=%b required 1", Err_underflow); end
    endtask

    task automatic test_reset_mid_flight();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            set_pred(1, 0, 32'h3000 + 32'(i) * 4, 32'h0);
            tick();
        end
        idle_inputs();
        n_cmp++; if (Count !== CW'(3)) begin
            n_fail++; $display("FAIL queued3: count=%0d required 3", Count); end
        #2 RESET = 0;
        model_reset();
        #1;
        n_cmp++; if (Count !== '0 || Stall_ID !== 1'b0 || Branch_addr_OUT !== 32'd0) begin
            n_fail++; $display("FAIL async_reset_queue: count=%0d stall=%b addr=%h required 0/0/0",
                               Count, Stall_ID, Branch_addr_OUT); end
        @(negedge CLK);
        RESET = 1;
        set_pred(1, 0, 32'h3100, 32'h0);
        tick();
        set_pred(1, 0, 32'h3200, 32'h0);
        set_res(1, 1, 32'h3500);
        tick();
        idle_inputs();
        n_cmp++; if (Flush !== 1'b1 || Stall_ID !== 1'b1) begin
            n_fail++; $display("FAIL enter_flush: flush=%b stall=%b required 1/1", Flush, Stall_ID); end
        #2 RESET = 0;
        model_reset();
        #1;
        n_cmp++; if (Flush !== 1'b0 || Redirect_pc !== 32'd0 || Mispredicts !== 16'd0 || Stall_ID !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_flush: flush=%b redirect=%h mp=%0d stall=%b required 0/0/0/0",
                               Flush, Redirect_pc, Mispredicts, Stall_ID); end
        @(negedge CLK);
        RESET = 1;
        set_pred(1, 1, 32'h3300, 32'h3400);
        tick();
        idle_inputs();
        n_cmp++; if (Count !== CW'(1)) begin
            n_fail++; $display("FAIL push_after_reset: count=%0d required 1", Count); end
    endtask

    task automatic test_random();
        logic [VW-1:0] act, exp;
        logic [31:0]   tg [4];
        tg[0] = 32'h2000; tg[1] = 32'h2004; tg[2] = 32'h0; tg[3] = 32'hFFFF_FFF0;
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            Pred_valid  = ($urandom_range(0, 9) < 6);
            Pred_taken  = $urandom_range(0, 1);
            Pred_pc     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(1, 255)) * 4;
            Pred_target = tg[$urandom_range(0, 1)];
            Res_valid   = ($urandom_range(0, 9) < 5);
            Res_taken   = $urandom_range(0, 1);
            Res_target  = tg[$urandom_range(0, 3)];
            tick();
            act = {Branch_resolved, Branch_addr_OUT, Flush, Redirect_pc, Stall_ID, Count, Mispredicts, Err_underflow};
            exp = {m_br, m_addr, m_flush, m_redir,
                   (mq.size() == DEPTH) || (m_flush_left > 0), CW'(mq.size()), 16'(m_mp), m_err};
            n_cmp++; if (act !== exp) begin
                n_fail++; $display("FAIL random_cycle_%0d: got %h required %h", cyc, act, exp); end
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_correct_predict();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_full_and_order();
        test_underflow();
        test_reset_mid_flight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
